// File: rtl/sram_tdp_param.sv
// ---------------------------------------------------------------------------
// sram_tdp_param
//
// Parametrised true dual-port behavioural SRAM on one clock. Both ports can
// read or byte-write every cycle. The same-port read-during-write behaviour
// is selectable. An optional output register adds a second read stage.
// Collisions between the ports are defined and reported. After reset, a
// sweep can clear the array to a programmable word before any port access
// is accepted.
//
// Parameters:
//   DATA_W        word width in bits (a multiple of BYTE_W)
//   DEPTH         number of words (need not be a power of two)
//   ADDR_W        address width
//   BYTE_W        write-enable granularity in bits
//   READ_MODE     same-port dout on a write: 0 read-first, 1 write-first,
//                 2 no-change
//   OUT_REG       1 adds an output pipeline stage (read latency 2)
//   INIT_ON_RESET 1 runs the clearing sweep after reset
//   INIT_VALUE    word written by the sweep
//
// Ports:
//   clk               single clock for both ports
//   rst               synchronous active-high reset
//   init_busy         high while the clearing sweep runs (ports ignored)
//   ena / enb         port access enables
//   wea / web         per-byte write enables, all zero means a read
//   addra / addrb     word addresses
//   dina / dinb       write data
//   douta / doutb     read data
//   valida / validb   dout updated this cycle
//   coll              pulse for a same-address write/write or read/write
// ---------------------------------------------------------------------------
module sram_tdp_param #(
    parameter int                DATA_W        = 32,
    parameter int                DEPTH         = 8192,
    parameter int                ADDR_W        = $clog2(DEPTH),
    parameter int                BYTE_W        = 8,
    parameter int                READ_MODE     = 0,
    parameter int                OUT_REG       = 0,
    parameter int                INIT_ON_RESET = 1,
    parameter logic [DATA_W-1:0] INIT_VALUE    = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic                       init_busy,
    input  logic                       ena,
    input  logic [DATA_W/BYTE_W-1:0]   wea,
    input  logic [ADDR_W-1:0]          addra,
    input  logic [DATA_W-1:0]          dina,
    output logic [DATA_W-1:0]          douta,
    output logic                       valida,
    input  logic                       enb,
    input  logic [DATA_W/BYTE_W-1:0]   web,
    input  logic [ADDR_W-1:0]          addrb,
    input  logic [DATA_W-1:0]          dinb,
    output logic [DATA_W-1:0]          doutb,
    output logic                       validb,
    output logic                       coll
);

    localparam int                NBYTES    = DATA_W / BYTE_W;
    localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        INIT,
        READY
    } state_t;

    state_t state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              accA, accB;
    logic              inA, inB;
    logic              writeA, writeB;
    logic [DATA_W-1:0] oldA, oldB;
    logic [DATA_W-1:0] mergedA, mergedB;
    logic [NBYTES-1:0] memWeA, memWeB;

    logic [DATA_W-1:0] doutA_q, doutA_d;
    logic [DATA_W-1:0] doutB_q, doutB_d;
    logic              validA_q, validA_d;
    logic              validB_q, validB_d;
    logic              coll_q, coll_d;

    // The sweep FSM state and address counter. Reset either restarts the
    // sweep from address 0 or goes straight to READY when no sweep is wanted.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= (INIT_ON_RESET != 0) ? INIT : READY;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // INIT writes one word per cycle. Once the last word has been written,
    // the FSM hands the array over to the ports.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            INIT: begin
                cnt_d = cnt_q + ADDR_W'(1);
                if (cnt_q == LAST_ADDR) begin
                    state_d = READY;
                    cnt_d   = '0;
                end
            end
            READY: begin
                state_d = READY;
            end
            default: begin
                state_d = READY;
            end
        endcase
    end

    assign init_busy = (state_q == INIT);

    // Decode of each port's request. Reads of the array are guarded so that
    // an out-of-range address yields zero rather than an undefined word.
    always_comb begin
        accA    = (state_q == READY) && ena;
        accB    = (state_q == READY) && enb;
        inA     = ({1'b0, addra} < DEPTH_X);
        inB     = ({1'b0, addrb} < DEPTH_X);
        writeA  = (wea != '0);
        writeB  = (web != '0);
        oldA    = inA ? mem[addra] : '0;
        oldB    = inB ? mem[addrb] : '0;
        memWeA  = (accA && inA) ? wea : '0;
        memWeB  = (accB && inB) ? web : '0;
        mergedA = oldA;
        mergedB = oldB;
        for (int i = 0; i < NBYTES; i++) begin
            if (wea[i]) begin
                mergedA[i*BYTE_W +: BYTE_W] = dina[i*BYTE_W +: BYTE_W];
            end
            if (web[i]) begin
                mergedB[i*BYTE_W +: BYTE_W] = dinb[i*BYTE_W +: BYTE_W];
            end
        end
        if (!inA) begin
            mergedA = '0;
        end
        if (!inB) begin
            mergedB = '0;
        end
    end

    // Array writes. Port B's bytes are scheduled first and port A's last.
    // When both ports hit the same word, A therefore wins every byte both
    // ports enable, while bytes only B enables still take B's data. The
    // sweep owns the array while INIT is active.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == INIT) begin
                mem[cnt_q] <= INIT_VALUE;
            end else begin
                for (int i = 0; i < NBYTES; i++) begin
                    if (memWeB[i]) begin
                        mem[addrb][i*BYTE_W +: BYTE_W] <= dinb[i*BYTE_W +: BYTE_W];
                    end
                end
                for (int i = 0; i < NBYTES; i++) begin
                    if (memWeA[i]) begin
                        mem[addra][i*BYTE_W +: BYTE_W] <= dina[i*BYTE_W +: BYTE_W];
                    end
                end
            end
        end
    end

    // Port A's first-stage output. A read, or a read-first write, returns
    // the word as it was before this edge. A write-first write returns the
    // merged word. A no-change write leaves dout alone and raises no valid.
    always_comb begin
        doutA_d  = doutA_q;
        validA_d = 1'b0;
        if (accA) begin
            if (!writeA) begin
                doutA_d  = oldA;
                validA_d = 1'b1;
            end else if (READ_MODE == 0) begin
                doutA_d  = oldA;
                validA_d = 1'b1;
            end else if (READ_MODE == 1) begin
                doutA_d  = mergedA;
                validA_d = 1'b1;
            end
        end
    end

    // Port B's first-stage output, following the same rules as port A.
    always_comb begin
        doutB_d  = doutB_q;
        validB_d = 1'b0;
        if (accB) begin
            if (!writeB) begin
                doutB_d  = oldB;
                validB_d = 1'b1;
            end else if (READ_MODE == 0) begin
                doutB_d  = oldB;
                validB_d = 1'b1;
            end else if (READ_MODE == 1) begin
                doutB_d  = mergedB;
                validB_d = 1'b1;
            end
        end
    end

    // A collision is both ports on the same in-range word with at least one
    // of them writing. Two reads of one word are harmless and not reported.
    always_comb begin
        coll_d = accA && accB && inA && inB && (addra == addrb) && (writeA || writeB);
    end

    // First output stage. It holds dout between updates and pulses valid
    // and coll for one cycle only.
    always_ff @(posedge clk) begin
        if (rst) begin
            doutA_q  <= '0;
            doutB_q  <= '0;
            validA_q <= 1'b0;
            validB_q <= 1'b0;
            coll_q   <= 1'b0;
        end else begin
            doutA_q  <= doutA_d;
            doutB_q  <= doutB_d;
            validA_q <= validA_d;
            validB_q <= validB_d;
            coll_q   <= coll_d;
        end
    end

    generate
        if (OUT_REG != 0) begin : gOutReg
            logic [DATA_W-1:0] doutA2_q, doutB2_q;
            logic              validA2_q, validB2_q, coll2_q;

            // Optional second stage. It copies a word only when the first
            // stage produced one, so dout still holds between updates.
            // valid and coll are delayed by the same cycle as the data.
            always_ff @(posedge clk) begin
                if (rst) begin
                    doutA2_q  <= '0;
                    doutB2_q  <= '0;
                    validA2_q <= 1'b0;
                    validB2_q <= 1'b0;
                    coll2_q   <= 1'b0;
                end else begin
                    if (validA_q) begin
                        doutA2_q <= doutA_q;
                    end
                    if (validB_q) begin
                        doutB2_q <= doutB_q;
                    end
                    validA2_q <= validA_q;
                    validB2_q <= validB_q;
                    coll2_q   <= coll_q;
                end
            end

            assign douta  = doutA2_q;
            assign doutb  = doutB2_q;
            assign valida = validA2_q;
            assign validb = validB2_q;
            assign coll   = coll2_q;
        end else begin : gNoOutReg
            assign douta  = doutA_q;
            assign doutb  = doutB_q;
            assign valida = validA_q;
            assign validb = validB_q;
            assign coll   = coll_q;
        end
    endgenerate

endmodule

// File: tb/tb_sram_tdp_param.sv
// ---------------------------------------------------------------------------
// tb_sram_tdp_param
//
// Bench for sram_tdp_param. One stimulus stream drives five instances in
// parallel:
//   u0  read-first, no output register, with sweep
//   u1  write-first
//   u2  no-change
//   u3  read-first with the output register
//   u4  DEPTH 12 without a sweep, used for out-of-range addresses
// A word-level model of each instance predicts every output. Directed
// checks against hand-computed literals pin that model.
// ---------------------------------------------------------------------------
module tb_sram_tdp_param;

    localparam int          NI    = 5;
    localparam logic [31:0] INITV = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ena = 1'b0;
    logic        enb = 1'b0;
    logic [3:0]  wea = '0;
    logic [3:0]  web = '0;
    logic [3:0]  addra = '0;
    logic [3:0]  addrb = '0;
    logic [31:0] dina = '0;
    logic [31:0] dinb = '0;

    logic        busyW   [NI];
    logic [31:0] doutaW  [NI];
    logic [31:0] doutbW  [NI];
    logic        validaW [NI];
    logic        validbW [NI];
    logic        collW   [NI];

    int testsRun    = 0;
    int testsFailed = 0;

    always #5 clk = ~clk;

    sram_tdp_param #(.DATA_W(32), .DEPTH(16), .BYTE_W(8), .READ_MODE(0), .OUT_REG(0),
                     .INIT_ON_RESET(1), .INIT_VALUE(INITV)) u0 (
        .clk(clk), .rst(rst), .init_busy(busyW[0]),
        .ena(ena), .wea(wea), .addra(addra), .dina(dina), .douta(doutaW[0]), .valida(validaW[0]),
        .enb(enb), .web(web), .addrb(addrb), .dinb(dinb), .doutb(doutbW[0]), .validb(validbW[0]),
        .coll(collW[0]));

    sram_tdp_param #(.DATA_W(32), .DEPTH(16), .BYTE_W(8), .READ_MODE(1), .OUT_REG(0),
                     .INIT_ON_RESET(1), .INIT_VALUE(INITV)) u1 (
        .clk(clk), .rst(rst), .init_busy(busyW[1]),
        .ena(ena), .wea(wea), .addra(addra), .dina(dina), .douta(doutaW[1]), .valida(validaW[1]),
        .enb(enb), .web(web), .addrb(addrb), .dinb(dinb), .doutb(doutbW[1]), .validb(validbW[1]),
        .coll(collW[1]));

    sram_tdp_param #(.DATA_W(32), .DEPTH(16), .BYTE_W(8), .READ_MODE(2), .OUT_REG(0),
                     .INIT_ON_RESET(1), .INIT_VALUE(INITV)) u2 (
        .clk(clk), .rst(rst), .init_busy(busyW[2]),
        .ena(ena), .wea(wea), .addra(addra), .dina(dina), .douta(doutaW[2]), .valida(validaW[2]),
        .enb(enb), .web(web), .addrb(addrb), .dinb(dinb), .doutb(doutbW[2]), .validb(validbW[2]),
        .coll(collW[2]));

    sram_tdp_param #(.DATA_W(32), .DEPTH(16), .BYTE_W(8), .READ_MODE(0), .OUT_REG(1),
                     .INIT_ON_RESET(1), .INIT_VALUE(INITV)) u3 (
        .clk(clk), .rst(rst), .init_busy(busyW[3]),
        .ena(ena), .wea(wea), .addra(addra), .dina(dina), .douta(doutaW[3]), .valida(validaW[3]),
        .enb(enb), .web(web), .addrb(addrb), .dinb(dinb), .doutb(doutbW[3]), .validb(validbW[3]),
        .coll(collW[3]));

    sram_tdp_param #(.DATA_W(32), .DEPTH(12), .BYTE_W(8), .READ_MODE(0), .OUT_REG(0),
                     .INIT_ON_RESET(0), .INIT_VALUE(INITV)) u4 (
        .clk(clk), .rst(rst), .init_busy(busyW[4]),
        .ena(ena), .wea(wea), .addra(addra), .dina(dina), .douta(doutaW[4]), .valida(validaW[4]),
        .enb(enb), .web(web), .addrb(addrb), .dinb(dinb), .doutb(doutbW[4]), .validb(validbW[4]),
        .coll(collW[4]));

    function automatic int rmOf(input int k);
        case (k)
            1:       return 1;
            2:       return 2;
            default: return 0;
        endcase
    endfunction

    function automatic bit orOf(input int k);
        return (k == 3);
    endfunction

    function automatic int depthOf(input int k);
        return (k == 4) ? 12 : 16;
    endfunction

    function automatic bit initOf(input int k);
        return (k != 4);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] din,
                                          input logic [3:0] we);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) begin
            if (we[i]) r[i*8 +: 8] = din[i*8 +: 8];
        end
        return r;
    endfunction

    // Model state. known flags mark words whose contents the bench can
    // predict. The sweepless instance starts with an undefined array.
    logic        busyM  [NI];
    int          cntM   [NI];
    logic [31:0] memM   [NI][16];
    bit          knownM [NI][16];
    logic [31:0] s1dA [NI], s1dB [NI];
    logic        s1vA [NI], s1vB [NI], s1c [NI];
    bit          s1kA [NI], s1kB [NI];
    logic [31:0] outdA [NI], outdB [NI];
    logic        outvA [NI], outvB [NI], outc [NI];
    bit          outkA [NI], outkB [NI];
    bit          modelReady = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Outcome of one port's access from the read-mode rules. It returns the
    // new first-stage dout, valid and known flag.
    task automatic portResult(input logic en, input logic [3:0] we, input logic [31:0] din,
                              input logic [31:0] old, input bit oldK, input bit inR,
                              input int rm, input logic [31:0] dPrev, input bit kPrev,
                              output logic [31:0] dNew, output logic vNew, output bit kNew);
        dNew = dPrev;
        kNew = kPrev;
        vNew = 1'b0;
        if (en) begin
            if (we == 4'h0 || rm == 0) begin
                dNew = inR ? old : 32'h0;
                kNew = inR ? oldK : 1'b1;
                vNew = 1'b1;
            end else if (rm == 1) begin
                dNew = inR ? merge(old, din, we) : 32'h0;
                kNew = inR ? (oldK || we == 4'hF) : 1'b1;
                vNew = 1'b1;
            end
        end
    endtask

    task automatic modelStep(input int k);
        logic [31:0] oldA, oldB, pdA, pdB, nd;
        logic        pvA, pvB, pc, nv;
        bit          okA, okB, inA, inB, pkA, pkB, nk;
        if (rst) begin
            busyM[k] = initOf(k);
            cntM[k]  = 0;
            s1dA[k] = '0; s1vA[k] = 1'b0; s1kA[k] = 1'b1;
            s1dB[k] = '0; s1vB[k] = 1'b0; s1kB[k] = 1'b1;
            s1c[k]  = 1'b0;
            outdA[k] = '0; outvA[k] = 1'b0; outkA[k] = 1'b1;
            outdB[k] = '0; outvB[k] = 1'b0; outkB[k] = 1'b1;
            outc[k]  = 1'b0;
        end else begin
            pdA = s1dA[k]; pvA = s1vA[k]; pkA = s1kA[k];
            pdB = s1dB[k]; pvB = s1vB[k]; pkB = s1kB[k];
            pc  = s1c[k];
            if (busyM[k]) begin
                memM[k][cntM[k]]   = INITV;
                knownM[k][cntM[k]] = 1'b1;
                if (cntM[k] == depthOf(k) - 1) busyM[k] = 1'b0;
                cntM[k]++;
                s1vA[k] = 1'b0;
                s1vB[k] = 1'b0;
                s1c[k]  = 1'b0;
            end else begin
                inA  = (int'(addra) < depthOf(k));
                inB  = (int'(addrb) < depthOf(k));
                oldA = inA ? memM[k][addra] : 32'h0;
                oldB = inB ? memM[k][addrb] : 32'h0;
                okA  = inA ? knownM[k][addra] : 1'b1;
                okB  = inB ? knownM[k][addrb] : 1'b1;
                portResult(ena, wea, dina, oldA, okA, inA, rmOf(k), s1dA[k], s1kA[k], nd, nv, nk);
                s1dA[k] = nd; s1vA[k] = nv; s1kA[k] = nk;
                portResult(enb, web, dinb, oldB, okB, inB, rmOf(k), s1dB[k], s1kB[k], nd, nv, nk);
                s1dB[k] = nd; s1vB[k] = nv; s1kB[k] = nk;
                s1c[k] = ena && enb && inA && inB && (addra == addrb) && (wea != 0 || web != 0);
                if (enb && inB && web != 4'h0) begin
                    memM[k][addrb]   = merge(memM[k][addrb], dinb, web);
                    knownM[k][addrb] = knownM[k][addrb] || (web == 4'hF);
                end
                if (ena && inA && wea != 4'h0) begin
                    memM[k][addra]   = merge(memM[k][addra], dina, wea);
                    knownM[k][addra] = knownM[k][addra] || (wea == 4'hF);
                end
            end
            if (orOf(k)) begin
                if (pvA) begin outdA[k] = pdA; outkA[k] = pkA; end
                if (pvB) begin outdB[k] = pdB; outkB[k] = pkB; end
                outvA[k] = pvA;
                outvB[k] = pvB;
                outc[k]  = pc;
            end else begin
                outdA[k] = s1dA[k]; outvA[k] = s1vA[k]; outkA[k] = s1kA[k];
                outdB[k] = s1dB[k]; outvB[k] = s1vB[k]; outkB[k] = s1kB[k];
                outc[k]  = s1c[k];
            end
        end
    endtask

    // Advance every instance's model on each rising edge, using the inputs
    // the DUT is sampling on that same edge.
    always @(posedge clk) begin
        for (int k = 0; k < NI; k++) modelStep(k);
        modelReady = 1'b1;
    end

    // Compare every output of every instance against the model on each
    // falling edge. Data words the model cannot predict are skipped.
    always @(negedge clk) begin
        if (modelReady) begin
            for (int k = 0; k < NI; k++) begin
                checkOutput($sformatf("u%0d init_busy", k), 32'(busyW[k]), 32'(busyM[k]));
                checkOutput($sformatf("u%0d valida", k), 32'(validaW[k]), 32'(outvA[k]));
                checkOutput($sformatf("u%0d validb", k), 32'(validbW[k]), 32'(outvB[k]));
                checkOutput($sformatf("u%0d coll", k), 32'(collW[k]), 32'(outc[k]));
                if (outkA[k]) checkOutput($sformatf("u%0d douta", k), doutaW[k], outdA[k]);
                if (outkB[k]) checkOutput($sformatf("u%0d doutb", k), doutbW[k], outdB[k]);
            end
        end
    end

    // Drive one cycle's worth of port inputs and return just after the edge
    // that samples them, once the registered outputs have settled.
    task automatic applyStimulus(input logic ea, input logic [3:0] wa, input logic [3:0] aa,
                                 input logic [31:0] da, input logic eb, input logic [3:0] wb,
                                 input logic [3:0] ab, input logic [31:0] db);
        ena = ea; wea = wa; addra = aa; dina = da;
        enb = eb; web = wb; addrb = ab; dinb = db;
        @(posedge clk);
        #1;
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 4'h0, 4'h0, 32'h0);
    endtask

    task automatic waitSweep();
        int  n;
        bit  done;
        n    = 0;
        done = 1'b0;
        while (!done && n < 40) begin
            idleCycle();
            n++;
            if (!busyW[0]) done = 1'b1;
        end
        checkOutput("sweep length", 32'(n), 32'd16);
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) idleCycle();
        checkOutput("reset u0 init_busy", 32'(busyW[0]), 32'd1);
        checkOutput("reset u0 douta", doutaW[0], 32'h0);
        checkOutput("reset u0 valida", 32'(validaW[0]), 32'd0);
        checkOutput("reset u4 init_busy", 32'(busyW[4]), 32'd0);

        // Sweep restarted by a reset at edge 7.
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            idleCycle();
            checkOutput("sweep busy early", 32'(busyW[0]), 32'd1);
        end
        rst = 1'b1;
        idleCycle();
        rst = 1'b0;
        waitSweep();

        // Every word holds the sweep value. B reads the mirror address.
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 4'h0, 4'(i), 32'h0, 1'b1, 4'h0, 4'(15 - i), 32'h0);
            checkOutput("sweep word A", doutaW[0], 32'hDEAD_BEEF);
            checkOutput("sweep word B", doutbW[0], 32'hDEAD_BEEF);
        end

        // Byte enables.
        applyStimulus(1'b1, 4'hF, 4'd5, 32'h1122_3344, 1'b0, 4'h0, 4'h0, 32'h0);
        applyStimulus(1'b1, 4'h5, 4'd5, 32'hAABB_CCDD, 1'b0, 4'h0, 4'h0, 32'h0);
        applyStimulus(1'b1, 4'h0, 4'd5, 32'h0, 1'b0, 4'h0, 4'h0, 32'h0);
        checkOutput("byte enable merge", doutaW[0], 32'h11BB_33DD);

        // Read modes on a write to addr 3 holding zero.
        applyStimulus(1'b1, 4'hF, 4'd3, 32'h0, 1'b0, 4'h0, 4'h0, 32'h0);
        applyStimulus(1'b1, 4'h0, 4'd4, 32'h0, 1'b0, 4'h0, 4'h0, 32'h0);
        applyStimulus(1'b1, 4'hF, 4'd3, 32'h5A5A_5A5A, 1'b0, 4'h0, 4'h0, 32'h0);
        checkOutput("read-first douta", doutaW[0], 32'h0);
        checkOutput("read-first valida", 32'(validaW[0]), 32'd1);
        checkOutput("write-first douta", doutaW[1], 32'h5A5A_5A5A);
        checkOutput("no-change douta", doutaW[2], 32'hDEAD_BEEF);
        checkOutput("no-change valida", 32'(validaW[2]), 32'd0);

        // Write/write collision.
        applyStimulus(1'b1, 4'h3, 4'd9, 32'h1111_1111, 1'b1, 4'hF, 4'd9, 32'h2222_2222);
        checkOutput("ww coll pulse", 32'(collW[0]), 32'd1);
        idleCycle();
        checkOutput("ww coll cleared", 32'(collW[0]), 32'd0);
        applyStimulus(1'b1, 4'h0, 4'd9, 32'h0, 1'b1, 4'h0, 4'd9, 32'h0);
        checkOutput("ww result A", doutaW[0], 32'h2222_1111);
        checkOutput("ww result B", doutbW[0], 32'h2222_1111);
        checkOutput("rr no coll", 32'(collW[0]), 32'd0);

        // Cross-port read while the other port writes.
        applyStimulus(1'b1, 4'hF, 4'd2, 32'h3, 1'b0, 4'h0, 4'h0, 32'h0);
        applyStimulus(1'b1, 4'h0, 4'd2, 32'h0, 1'b1, 4'hF, 4'd2, 32'h7);
        checkOutput("rw reader old", doutaW[0], 32'h3);
        checkOutput("rw reader old wf", doutaW[1], 32'h3);
        checkOutput("rw coll", 32'(collW[0]), 32'd1);
        applyStimulus(1'b1, 4'h0, 4'd2, 32'h0, 1'b0, 4'h0, 4'h0, 32'h0);
        checkOutput("rw new value", doutaW[0], 32'h7);

        // Out-of-range and last-word accesses on the 12-word instance.
        applyStimulus(1'b1, 4'hF, 4'd13, 32'hCAFE_0000, 1'b0, 4'h0, 4'h0, 32'h0);
        applyStimulus(1'b1, 4'h0, 4'd13, 32'h0, 1'b0, 4'h0, 4'h0, 32'h0);
        checkOutput("oob read zero", doutaW[4], 32'h0);
        checkOutput("oob read valid", 32'(validaW[4]), 32'd1);
        checkOutput("in-range 13 on u0", doutaW[0], 32'hCAFE_0000);
        applyStimulus(1'b1, 4'hF, 4'd11, 32'h1234_5678, 1'b0, 4'h0, 4'h0, 32'h0);
        applyStimulus(1'b1, 4'h0, 4'd11, 32'h0, 1'b0, 4'h0, 4'h0, 32'h0);
        checkOutput("last word u4", doutaW[4], 32'h1234_5678);
        applyStimulus(1'b1, 4'hF, 4'd13, 32'h1, 1'b1, 4'hF, 4'd13, 32'h2);
        checkOutput("oob no coll", 32'(collW[4]), 32'd0);

        // Back-to-back reads through the output register.
        applyStimulus(1'b1, 4'hF, 4'd0, 32'hA0, 1'b0, 4'h0, 4'h0, 32'h0);
        applyStimulus(1'b1, 4'hF, 4'd1, 32'hA1, 1'b0, 4'h0, 4'h0, 32'h0);
        applyStimulus(1'b1, 4'h0, 4'd0, 32'h0, 1'b0, 4'h0, 4'h0, 32'h0);
        applyStimulus(1'b1, 4'h0, 4'd1, 32'h0, 1'b0, 4'h0, 4'h0, 32'h0);
        checkOutput("outreg word 0", doutaW[3], 32'hA0);
        checkOutput("outreg valid 0", 32'(validaW[3]), 32'd1);
        applyStimulus(1'b1, 4'h0, 4'd2, 32'h0, 1'b0, 4'h0, 4'h0, 32'h0);
        checkOutput("outreg word 1", doutaW[3], 32'hA1);
        checkOutput("outreg valid 1", 32'(validaW[3]), 32'd1);
        idleCycle();
        checkOutput("outreg word 2", doutaW[3], 32'h7);
        checkOutput("outreg valid 2", 32'(validaW[3]), 32'd1);
        idleCycle();
        checkOutput("outreg valid end", 32'(validaW[3]), 32'd0);
        checkOutput("outreg hold", doutaW[3], 32'h7);

        // Reset in the middle of a read stream.
        applyStimulus(1'b1, 4'h0, 4'd0, 32'h0, 1'b0, 4'h0, 4'h0, 32'h0);
        applyStimulus(1'b1, 4'h0, 4'd1, 32'h0, 1'b0, 4'h0, 4'h0, 32'h0);
        rst = 1'b1;
        applyStimulus(1'b1, 4'h0, 4'd2, 32'h0, 1'b0, 4'h0, 4'h0, 32'h0);
        checkOutput("midreset douta", doutaW[3], 32'h0);
        checkOutput("midreset valida", 32'(validaW[3]), 32'd0);
        rst = 1'b0;
        waitSweep();

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
